rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Write-side front end for the 32x32 integer register file of the 5-stage RISC-V pipeline. It owns the register file's single write port (`WE3`/`WA3`/`WD3`) and shares it between the in-order writeback stage and a long-latency multicycle unit (divider/multiplier). Multicycle results are buffered in a small FIFO. A destination scoreboard lets decode stall on registers whose results are still pending.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `FIFO_DEPTH`, 2: multicycle result buffer entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pipe_we`  in  1  writeback-stage write enable.
- `pipe_wa`  in  5  writeback destination.
- `pipe_wd`  in  XLEN  writeback data.
- `mc_valid`  in  1  multicycle result offered.
- `mc_ready`  out  1  arbiter can accept a multicycle result.
- `mc_wa`  in  5  multicycle destination.
- `mc_wd`  in  XLEN  multicycle data.
- `issue_valid`  in  1  decode issues a multicycle op this cycle.
- `issue_rd`  in  5  destination of the issued op.
- `rs1`, `rs2`  in  5 each  decode source registers.
- `hazard`  out  1  decode must stall.
- `busy`  out  32  scoreboard; bit i set means a result for xi is pending.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.
- `wb_conflict`  out  1  sticky protocol-violation flag.
- `rf_we`  out  1  drives `WE3`.
- `rf_wa`  out  5  drives `WA3`.
- `rf_wd`  out  XLEN  drives `WD3`.

## Operation
- Port priority, evaluated each cycle:
  - A pipeline write (`pipe_we` with `pipe_wa` != 0) has priority. It passes through combinationally: `rf_we`=1, `rf_wa`=`pipe_wa`, `rf_wd`=`pipe_wd`.
  - A pipeline write with `pipe_wa`=0 is dropped. `rf_we` is not asserted for it, and the port is free for the FIFO that cycle.
  - Otherwise, if the FIFO is not empty, the head entry drives `rf_*` and is popped at the next rising edge.
  - Otherwise `rf_we`=0, `rf_wa`=0, `rf_wd`=0.
- Multicycle handshake:
  - A transfer occurs on a rising edge where `mc_valid` and `mc_ready` are both high.
  - `mc_ready` = (`fifo_count` < `FIFO_DEPTH`) and not in reset. There is no look-through: when the FIFO is full, a same-cycle pop does not raise `mc_ready`.
  - A transfer with `mc_wa`=0 is accepted and discarded; nothing is pushed.
- Scoreboard:
  - `issue_valid` with `issue_rd` != 0 sets `busy[issue_rd]` at the rising edge.
  - When a FIFO entry is written to the register file, `busy[wa]` clears at the rising edge that pops it.
  - If a set and a clear hit the same register in the same edge, the set wins.
  - `busy[0]` is always 0.
- `hazard` (combinational) = `busy[rs1]` | `busy[rs2]` | (`issue_valid` & `busy[issue_rd]`), with x0 terms forced to 0. This covers both RAW and WAW stalls.
- `wb_conflict` is set, and held until reset, when either of these occurs:
  - a pipeline write targets a busy register;
  - an accepted multicycle result targets a non-busy register (other than x0).

## Timing
- Reset (asynchronous assert and release) returns the block to the following values:
  - FIFO empty, `fifo_count`=0;
  - `busy`=0, `wb_conflict`=0;
  - `mc_ready`=0 while `rst` is high, 1 on the first cycle after release;
  - `rf_we`=0 while `rst` is high, regardless of `pipe_we`.
- If reset is asserted mid-operation, buffered results and pending scoreboard bits are discarded with no writes.
- `rf_*` are valid combinationally within the cycle. The register file captures them on the falling edge of the same cycle.
- Minimum multicycle latency: accepted at edge N, written in cycle N+1 and popped at edge N+1, provided no pipeline write occurs in that cycle.
- A continuous stream of pipeline writes starves the FIFO. Fairness is provided by the pipeline, which inserts bubbles.
- Push and pop in the same edge leave `fifo_count` unchanged. The FIFO pointers wrap modulo `FIFO_DEPTH`.
- A `busy` bit set at edge N is visible on `hazard` in cycle N+1. A `busy` bit cleared at edge N is visible as non-stalling in cycle N+1.

## Configuration
- `RF_ARB_BYPASS_EN` defined:
  - When the FIFO is empty and there is no pipeline write (or the pipeline write targets x0), an offered multicycle result drives `rf_*` directly in the same cycle.
  - Its handshake completes at the following rising edge without being pushed, and `busy` clears at that edge.
  - Zero-cycle buffering.
- Not defined: every multicycle result passes through the FIFO, with a minimum latency of one cycle as above.

## Test plan
- Reset with `pipe_we`=1, `pipe_wa`=5 held -> `rf_we`=0, `busy`=0, `mc_ready`=0. After release -> `rf_we`=1, `rf_wa`=5, `mc_ready`=1.
- Issue rd=7, then 3 cycles later accept `mc_wa`=7, `mc_wd`=0xDEADBEEF with no pipeline writes:
  - `hazard`=1 for `rs1`=7 until the write;
  - `rf_wa`=7, `rf_wd`=0xDEADBEEF exactly one cycle after acceptance (same cycle with `RF_ARB_BYPASS_EN`);
  - `busy[7]` clears.
- With `FIFO_DEPTH`=2, accept results for x3 and x4 while the pipeline writes every cycle -> `fifo_count`=2, `mc_ready`=0. A third offer stalls. After the pipeline idles, x3 then x4 are written in order.
- Pipeline write to x0 while the FIFO holds x9 -> `rf_we`=1, `rf_wa`=9 that cycle. x0 reads 0 afterwards.
- Same-edge pop of x12 and issue of rd=12 -> `busy[12]` remains 1.
- Pipeline write to busy x12 -> `wb_conflict`=1 and stays 1 until `rst`.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multicycle results
// are buffered in a FIFO, and a destination scoreboard drives decode stalls.
// Optional RF_ARB_BYPASS_EN: an offered multicycle result writes directly when the port is idle.
module rf_write_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_wa,
  input  logic [XLEN-1:0]               pipe_wd,
  input  logic                          mc_valid,
  output logic                          mc_ready,
  input  logic [4:0]                    mc_wa,
  input  logic [XLEN-1:0]               mc_wd,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  output logic                          hazard,
  output logic [31:0]                   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wb_conflict,
  output logic                          rf_we,
  output logic [4:0]                    rf_wa,
  output logic [XLEN-1:0]               rf_wd
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      wa_mem_q [FIFO_DEPTH];
  logic [4:0]      wa_mem_d [FIFO_DEPTH];
  logic [XLEN-1:0] wd_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] wd_mem_d [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            conflict_q, conflict_d;

  logic            pipe_hit;
  logic            fifo_empty;
  logic            mc_fire;
  logic            pop;
  logic            push;
  logic            byp;
  logic [4:0]      head_wa;

  always_comb begin
    pipe_hit   = pipe_we && (pipe_wa != 5'd0);
    fifo_empty = (count_q == '0);
    head_wa    = wa_mem_q[rd_ptr_q];
    // No look-through: a full FIFO stays not-ready even when it pops this cycle.
    mc_ready   = !rst && (count_q < CW'(FIFO_DEPTH));
    mc_fire    = mc_valid && mc_ready;
    pop        = !rst && !pipe_hit && !fifo_empty;
`ifdef RF_ARB_BYPASS_EN
    byp        = !pipe_hit && fifo_empty && mc_fire;
`else
    byp        = 1'b0;
`endif
    push       = mc_fire && (mc_wa != 5'd0) && !byp;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (rst) begin
      rf_we = 1'b0;
    end else if (pipe_hit) begin
      rf_we = 1'b1;
      rf_wa = pipe_wa;
      rf_wd = pipe_wd;
    end else if (!fifo_empty) begin
      rf_we = 1'b1;
      rf_wa = head_wa;
      rf_wd = wd_mem_q[rd_ptr_q];
    end else if (byp && (mc_wa != 5'd0)) begin
      rf_we = 1'b1;
      rf_wa = mc_wa;
      rf_wd = mc_wd;
    end
  end

  always_comb begin
    wa_mem_d = wa_mem_q;
    wd_mem_d = wd_mem_q;
    if (push) begin
      wa_mem_d[wr_ptr_q] = mc_wa;
      wd_mem_d[wr_ptr_q] = mc_wd;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // Clears first so that a same-edge issue to the same register wins.
    busy_d = busy_q;
    if (pop) busy_d[head_wa] = 1'b0;
    if (byp) busy_d[mc_wa] = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    conflict_d = conflict_q
               | (pipe_hit && busy_q[pipe_wa])
               | (mc_fire && (mc_wa != 5'd0) && !busy_q[mc_wa]);
  end

  always_comb begin
    hazard = ((rs1 != 5'd0) && busy_q[rs1])
           | ((rs2 != 5'd0) && busy_q[rs2])
           | (issue_valid && (issue_rd != 5'd0) && busy_q[issue_rd]);
    busy        = busy_q;
    fifo_count  = count_q;
    wb_conflict = conflict_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wa_mem_q   <= '{default: '0};
      wd_mem_q   <= '{default: '0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      wa_mem_q   <= wa_mem_d;
      wd_mem_q   <= wd_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic with resets.
module tb_rf_write_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_wa;
  logic [31:0] mc_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic [31:0] busy;
  logic [1:0]  fifo_count;
  logic        wb_conflict;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  ent_t        mq[$];
  logic [31:0] mbusy = '0;
  logic        mconf = 1'b0;

  rf_write_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wa(mc_wa), .mc_wd(mc_wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .busy(busy), .fifo_count(fifo_count), .wb_conflict(wb_conflict),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample at the falling edge, compare against the model, then advance the model.
  task automatic sample();
    logic        hit, byp, popd, acc, e_ready, e_haz, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    @(negedge clk);
    if (rst) begin
      mq.delete();
      mbusy = '0;
      mconf = 1'b0;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_mc_ready", mc_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_conflict", wb_conflict, 0);
      return;
    end
    hit     = pipe_we && (pipe_wa != 0);
    e_ready = mq.size() < FIFO_DEPTH;
    byp     = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    byp     = !hit && (mq.size() == 0) && mc_valid;
`endif
    e_we = 0; e_wa = 0; e_wd = 0;
    if (hit) begin
      e_we = 1; e_wa = pipe_wa; e_wd = pipe_wd;
    end else if (mq.size() > 0) begin
      e_we = 1; e_wa = mq[0].wa; e_wd = mq[0].wd;
    end else if (byp && mc_wa != 0) begin
      e_we = 1; e_wa = mc_wa; e_wd = mc_wd;
    end
    e_haz = (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2])
         || (issue_valid && issue_rd != 0 && mbusy[issue_rd]);
    chk("rf_we", rf_we, e_we);
    chk("rf_wa", rf_wa, e_wa);
    chk("rf_wd", rf_wd, e_wd);
    chk("mc_ready", mc_ready, e_ready);
    chk("hazard", hazard, e_haz);
    chk("busy", busy, mbusy);
    chk("fifo_count", fifo_count, mq.size());
    chk("wb_conflict", wb_conflict, mconf);

    acc  = mc_valid && e_ready;
    popd = !hit && (mq.size() > 0);
    if (hit && mbusy[pipe_wa]) mconf = 1'b1;
    if (acc && mc_wa != 0 && !mbusy[mc_wa]) mconf = 1'b1;
    if (popd) begin
      mbusy[mq[0].wa] = 1'b0;
      void'(mq.pop_front());
    end
    if (byp && mc_wa != 0) mbusy[mc_wa] = 1'b0;
    if (acc && mc_wa != 0 && !byp) mq.push_back('{wa: mc_wa, wd: mc_wd});
    if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic idle();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    mc_valid = 0; mc_wa = 0; mc_wd = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset holds the write port off even with a live pipeline write.
    pipe_we = 1; pipe_wa = 5; pipe_wd = 32'h55;
    sample();
    chk("lit_rst_we", rf_we, 0);
    chk("lit_rst_ready", mc_ready, 0);
    chk("lit_rst_busy", busy, 0);
    adv();
    rst = 1'b0;
    sample();
    chk("lit_rel_we", rf_we, 1);
    chk("lit_rel_wa", rf_wa, 5);
    chk("lit_rel_ready", mc_ready, 1);
    adv();

    // Issue x7, result three cycles later.
    idle();
    issue_valid = 1; issue_rd = 7;
    step();
    idle();
    rs1 = 7;
    sample();
    chk("lit_haz7", hazard, 1);
    adv();
    step();
    step();
    mc_valid = 1; mc_wa = 7; mc_wd = 32'hDEADBEEF;
    sample();
    chk("lit_haz7_acc", hazard, 1);
`ifdef RF_ARB_BYPASS_EN
    chk("lit_byp_wa", rf_wa, 7);
    chk("lit_byp_wd", rf_wd, 32'hDEADBEEF);
`endif
    adv();
    mc_valid = 0;
    sample();
`ifndef RF_ARB_BYPASS_EN
    chk("lit_wr7_we", rf_we, 1);
    chk("lit_wr7_wa", rf_wa, 7);
    chk("lit_wr7_wd", rf_wd, 32'hDEADBEEF);
    chk("lit_haz7_wr", hazard, 1);
`endif
    adv();
    sample();
    chk("lit_busy7", busy[7], 0);
    chk("lit_haz7_clr", hazard, 0);
    adv();

    // Fill the FIFO under continuous pipeline writes.
    idle();
    issue_valid = 1; issue_rd = 3; step();
    issue_rd = 4; step();
    idle();
    pipe_we = 1; pipe_wa = 10; pipe_wd = 32'h1010;
    mc_valid = 1; mc_wa = 3; mc_wd = 32'h3333; step();
    mc_wa = 4; mc_wd = 32'h4444; step();
    mc_wa = 5; mc_wd = 32'h5555;
    sample();
    chk("lit_full_count", fifo_count, 2);
    chk("lit_full_ready", mc_ready, 0);
    adv();
    step();
    idle();
    sample();
    chk("lit_order3_wa", rf_wa, 3);
    chk("lit_order3_wd", rf_wd, 32'h3333);
    adv();
    sample();
    chk("lit_order4_wa", rf_wa, 4);
    adv();

    // x0 pipeline write leaves the port to the FIFO.
    issue_valid = 1; issue_rd = 9; step();
    idle();
    pipe_we = 1; pipe_wa = 10; mc_valid = 1; mc_wa = 9; mc_wd = 32'h9999; step();
    idle();
    pipe_we = 1; pipe_wa = 0; pipe_wd = 32'hFFFF;
    sample();
    chk("lit_x0_we", rf_we, 1);
    chk("lit_x0_wa", rf_wa, 9);
    adv();

    // Same-edge pop and re-issue of x12.
    idle();
    issue_valid = 1; issue_rd = 12; step();
    idle();
    pipe_we = 1; pipe_wa = 10; mc_valid = 1; mc_wa = 12; mc_wd = 32'hC; step();
    idle();
    issue_valid = 1; issue_rd = 12; step();
    idle();
    sample();
    chk("lit_busy12", busy[12], 1);
    chk("lit_noconf", wb_conflict, 0);
    adv();

    // Pipeline write to busy x12 is a sticky violation.
    pipe_we = 1; pipe_wa = 12; step();
    idle();
    for (int i = 0; i < 3; i++) step();
    sample();
    chk("lit_conf_sticky", wb_conflict, 1);
    adv();
    rst = 1'b1;
    sample();
    chk("lit_conf_rst", wb_conflict, 0);
    adv();
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom);
      pipe_we     = 1'($urandom);
      pipe_wa     = 5'($urandom);
      if (mbusy[pipe_wa] && $urandom_range(0, 7) != 0) pipe_wa = 0;
      pipe_wd     = $urandom;
      mc_valid    = ($urandom_range(0, 2) == 0);
      mc_wa       = 5'($urandom);
      if (mbusy != 0 && $urandom_range(0, 7) != 0) begin
        while (!mbusy[mc_wa]) mc_wa = 5'($urandom);
      end
      mc_wd       = $urandom;
      rs1         = 5'($urandom);
      rs2         = 5'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
